// File: rtl/codec_sample_fetcher.sv
// Playback sample fetcher: reads 2 (mono) or 4 (stereo) little-endian bytes per
// serializer request from the active ping-pong half and presents L/R PCM samples.
module codec_sample_fetcher #(
  parameter int BUFFER_ADDR_BITS = 9
) (
  input  logic                        clk,
  input  logic                        rst,
  output logic [BUFFER_ADDR_BITS-1:0] codec_buffer_addr_o,
  output logic                        codec_buffer_sel_o,
  input  logic [7:0]                  codec_buffer_data_i,
  input  logic                        codec_buffer_filled_i,
  output logic                        codec_buffer_empty_o,
  input  logic [7:0]                  wav_info_audio_channels_i,
  input  logic                        sample_req_i,
  output logic [15:0]                 sample_left_o,
  output logic [15:0]                 sample_right_o,
  output logic                        sample_valid_o,
  output logic                        underrun_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_LAST   = 2'd2,
    S_SILENT = 2'd3
  } state_t;

  localparam logic [BUFFER_ADDR_BITS-1:0] PTR_ONE = {{(BUFFER_ADDR_BITS-1){1'b0}}, 1'b1};
  localparam logic [BUFFER_ADDR_BITS-1:0] PTR_MAX = {BUFFER_ADDR_BITS{1'b1}};

  state_t                        state_q, state_d;
  logic [BUFFER_ADDR_BITS-1:0]   ptr_q, ptr_d;
  logic                          sel_q, sel_d;
  logic [2:0]                    cnt_q, cnt_d;
  logic                          stereo_q, stereo_d;
  logic [23:0]                   bytes_q, bytes_d;
  logic [15:0]                   left_q, left_d;
  logic [15:0]                   right_q, right_d;
  logic                          valid_q, valid_d;
  logic                          underrun_q, underrun_d;
  logic                          empty_q, empty_d;
  logic [2:0]                    last_idx_s;

  assign last_idx_s = stereo_q ? 3'd3 : 3'd1;

  // Next-state and datapath: one address per FETCH cycle; data trails it by one cycle.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    sel_d      = sel_q;
    cnt_d      = cnt_q;
    stereo_d   = stereo_q;
    bytes_d    = bytes_q;
    left_d     = left_q;
    right_d    = right_q;
    valid_d    = 1'b0;
    underrun_d = 1'b0;
    empty_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (sample_req_i) begin
          stereo_d = (wav_info_audio_channels_i != 8'd1);
          cnt_d    = 3'd0;
          state_d  = codec_buffer_filled_i ? S_FETCH : S_SILENT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FETCH: begin
        case (cnt_q)
          3'd1:    bytes_d[7:0]   = codec_buffer_data_i;
          3'd2:    bytes_d[15:8]  = codec_buffer_data_i;
          3'd3:    bytes_d[23:16] = codec_buffer_data_i;
          default: bytes_d        = bytes_q;
        endcase
        ptr_d = ptr_q + PTR_ONE;
        cnt_d = cnt_q + 3'd1;
        // Leaving the last byte of a half hands it back to the writer.
        if (ptr_q == PTR_MAX) begin
          empty_d = 1'b1;
          sel_d   = ~sel_q;
        end else begin
          empty_d = 1'b0;
        end
        if (cnt_q == last_idx_s) begin
          state_d = S_LAST;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_LAST: begin
        if (stereo_q) begin
          left_d  = bytes_q[15:0];
          right_d = {codec_buffer_data_i, bytes_q[23:16]};
        end else begin
          left_d  = {codec_buffer_data_i, bytes_q[7:0]};
          right_d = {codec_buffer_data_i, bytes_q[7:0]};
        end
        valid_d = 1'b1;
        state_d = S_IDLE;
      end
      S_SILENT: begin
        left_d     = 16'd0;
        right_d    = 16'd0;
        valid_d    = 1'b1;
        underrun_d = 1'b1;
        state_d    = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      sel_q      <= 1'b0;
      cnt_q      <= 3'd0;
      stereo_q   <= 1'b0;
      bytes_q    <= 24'd0;
      left_q     <= 16'd0;
      right_q    <= 16'd0;
      valid_q    <= 1'b0;
      underrun_q <= 1'b0;
      empty_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      sel_q      <= sel_d;
      cnt_q      <= cnt_d;
      stereo_q   <= stereo_d;
      bytes_q    <= bytes_d;
      left_q     <= left_d;
      right_q    <= right_d;
      valid_q    <= valid_d;
      underrun_q <= underrun_d;
      empty_q    <= empty_d;
    end
  end

  assign codec_buffer_addr_o  = ptr_q;
  assign codec_buffer_sel_o   = sel_q;
  assign codec_buffer_empty_o = empty_q;
  assign sample_left_o        = left_q;
  assign sample_right_o       = right_q;
  assign sample_valid_o       = valid_q;
  assign underrun_o           = underrun_q;

endmodule

// File: tb/tb_codec_sample_fetcher.sv
// Bench for codec_sample_fetcher with 8-byte halves: directed frame table,
// reset-mid-fetch sequence, then random frames checked against a linear-ring model.
module tb_codec_sample_fetcher;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  addr;
  logic        sel;
  logic [7:0]  data;
  logic        filled;
  logic        empty;
  logic [7:0]  chan;
  logic        req;
  logic [15:0] left, right;
  logic        valid, underrun;

  logic [7:0]  mem [2][8];
  int          n_cmp = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  // Buffer RAM: data for the presented half/address appears the following cycle.
  always @(posedge clk) data <= mem[sel][addr];

  codec_sample_fetcher #(.BUFFER_ADDR_BITS(3)) dut (
    .clk(clk), .rst(rst),
    .codec_buffer_addr_o(addr), .codec_buffer_sel_o(sel),
    .codec_buffer_data_i(data), .codec_buffer_filled_i(filled),
    .codec_buffer_empty_o(empty), .wav_info_audio_channels_i(chan),
    .sample_req_i(req), .sample_left_o(left), .sample_right_o(right),
    .sample_valid_o(valid), .underrun_o(underrun)
  );

  typedef struct {
    logic [7:0]  ch;
    bit          fil;
    bit          busy;
    int          lat;
    logic [15:0] l;
    logic [15:0] r;
    bit          und;
    int          emp;
    bit          sel;
    logic [2:0]  a0;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, " addr"}, {29'd0, addr}, 32'd0);
    chk({tag, " sel"}, {31'd0, sel}, 32'd0);
    chk({tag, " left"}, {16'd0, left}, 32'd0);
    chk({tag, " right"}, {16'd0, right}, 32'd0);
    chk({tag, " valid"}, {31'd0, valid}, 32'd0);
    chk({tag, " underrun"}, {31'd0, underrun}, 32'd0);
    chk({tag, " empty"}, {31'd0, empty}, 32'd0);
  endtask

  // Issue one request and observe a fixed window; all checks use the supplied expectations.
  task automatic run_frame(input vec_t v);
    logic [2:0]  addr_seen [1:12];
    int          nval, nemp, lat, n;
    logic [15:0] gl, gr;
    logic        gu;
    nval = 0; nemp = 0; lat = -1; gl = 16'hxxxx; gr = 16'hxxxx; gu = 1'bx;
    n = v.fil ? ((v.ch == 8'd1) ? 2 : 4) : 0;
    @(negedge clk);
    chan = v.ch; filled = v.fil; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      addr_seen[k] = addr;
      if (valid) begin
        nval++;
        if (lat < 0) begin
          lat = k - 1; gl = left; gr = right; gu = underrun;
        end
      end
      if (empty) nemp++;
      if (v.busy && k == 2) req = 1'b1;
      if (v.busy && k == 3) req = 1'b0;
      if (v.fil && k == 2) filled = 1'b0;
      if (k < 12) @(negedge clk);
    end
    chk("valid_count", nval, 32'd1);
    chk("latency", lat, v.lat);
    chk("left", {16'd0, gl}, {16'd0, v.l});
    chk("right", {16'd0, gr}, {16'd0, v.r});
    chk("underrun", {31'd0, gu}, {31'd0, v.und});
    chk("empty_count", nemp, v.emp);
    chk("sel_after", {31'd0, sel}, {31'd0, v.sel});
    chk("hold_left", {16'd0, left}, {16'd0, v.l});
    chk("addr_first", {29'd0, addr_seen[1]}, {29'd0, v.a0});
    for (int j = 1; j < n; j++) begin
      logic [2:0] ea;
      ea = v.a0 + j[2:0];
      chk("addr_seq", {29'd0, addr_seen[j+1]}, {29'd0, ea});
    end
  endtask

  // Reference model: the two halves form one 16-byte ring consumed in order.
  int ref_pos;

  task automatic model_frame(input logic [7:0] ch, input bit fil, input bit busy, output vec_t v);
    logic [7:0] b [4];
    int n, p;
    v.ch = ch; v.fil = fil; v.busy = busy && fil;
    v.a0 = 3'(ref_pos % 8);
    if (fil) begin
      n = (ch == 8'd1) ? 2 : 4;
      for (int j = 0; j < n; j++) begin
        p = (ref_pos + j) % 16;
        b[j] = mem[p / 8][p % 8];
      end
      v.l   = {b[1], b[0]};
      v.r   = (n == 4) ? {b[3], b[2]} : {b[1], b[0]};
      v.lat = n + 1;
      v.und = 1'b0;
      v.emp = ((ref_pos % 8) + n == 8) ? 1 : 0;
      ref_pos = (ref_pos + n) % 16;
    end else begin
      v.l = 16'd0; v.r = 16'd0; v.lat = 1; v.und = 1'b1; v.emp = 0;
    end
    v.sel = (ref_pos >= 8);
  endtask

  vec_t tbl [9];

  initial begin
    vec_t v;
    int   nval;
    mem[0][0] = 8'h34; mem[0][1] = 8'h12; mem[0][2] = 8'h78; mem[0][3] = 8'h56;
    mem[0][4] = 8'hCD; mem[0][5] = 8'hAB; mem[0][6] = 8'h01; mem[0][7] = 8'h80;
    for (int i = 0; i < 8; i++) mem[1][i] = 8'(8'h11 * (i + 1));
    //             ch     fil   busy  lat  left      right     und   emp sel   a0
    tbl[0] = '{8'd1, 1'b1, 1'b0, 3, 16'h1234, 16'h1234, 1'b0, 0, 1'b0, 3'd0};
    tbl[1] = '{8'd1, 1'b0, 1'b0, 1, 16'h0000, 16'h0000, 1'b1, 0, 1'b0, 3'd2};
    tbl[2] = '{8'd1, 1'b1, 1'b0, 3, 16'h5678, 16'h5678, 1'b0, 0, 1'b0, 3'd2};
    tbl[3] = '{8'd2, 1'b1, 1'b1, 5, 16'hABCD, 16'h8001, 1'b0, 1, 1'b1, 3'd4};
    tbl[4] = '{8'd2, 1'b1, 1'b0, 5, 16'h2211, 16'h4433, 1'b0, 0, 1'b1, 3'd0};
    tbl[5] = '{8'd0, 1'b1, 1'b0, 5, 16'h6655, 16'h8877, 1'b0, 1, 1'b0, 3'd4};
    tbl[6] = '{8'd1, 1'b1, 1'b0, 3, 16'h1234, 16'h1234, 1'b0, 0, 1'b0, 3'd0};
    tbl[7] = '{8'd1, 1'b1, 1'b0, 3, 16'h5678, 16'h5678, 1'b0, 0, 1'b0, 3'd2};
    tbl[8] = '{8'd2, 1'b1, 1'b0, 5, 16'hABCD, 16'h8001, 1'b0, 1, 1'b1, 3'd4};

    rst = 1'b1; req = 1'b0; filled = 1'b0; chan = 8'd1;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    foreach (tbl[i]) run_frame(tbl[i]);

    // Reset during a stereo fetch from half 1: outputs clear, sel back to 0, no valid.
    @(negedge clk);
    chan = 8'd2; filled = 1'b1; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrst");
    rst = 1'b0;
    nval = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (valid) nval++;
    end
    chk("midrst_no_valid", nval, 32'd0);
    ref_pos = 0;
    model_frame(8'd1, 1'b1, 1'b0, v);
    run_frame(v);

    // Random frames against the ring model; stereo only on 4-byte boundaries.
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 8; j++) mem[i][j] = 8'($urandom_range(0, 255));
    for (int t = 0; t < 40; t++) begin
      logic [7:0] ch;
      bit fil, busy;
      ch   = 8'd1;
      if (ref_pos % 4 == 0) begin
        case ($urandom_range(0, 3))
          0: ch = 8'd1;
          1: ch = 8'd2;
          2: ch = 8'd0;
          default: ch = 8'($urandom_range(3, 255));
        endcase
      end
      fil  = ($urandom_range(0, 3) != 0);
      busy = ($urandom_range(0, 1) == 1);
      model_frame(ch, fil, busy, v);
      run_frame(v);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
